// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Digit counter width: ceil(log2(n)), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub.
interface seq_addsub_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, res, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, res, c_out, ovf, zero
  );

endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple full-adder chain, reused for every digit.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out    = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Digit-serial two's-complement adder/subtractor, one CHUNK-bit digit per clock.
// Define SEQ_ADDSUB_FLAGS_EN to build the ovf/zero flag logic; otherwise both are tied low.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_addsub_if.slave  bus
);

  localparam int unsigned N        = WIDTH / CHUNK;
  localparam int unsigned CntW     = cnt_width(N);
  localparam bit          ParamsOk = width_ok(WIDTH, CHUNK);

  if (!ParamsOk) begin : g_bad_params
    $error("seq_addsub: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             c_out_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] sum;
  logic             c_top;
  logic             c_msb;
  logic [WIDTH-1:0] res_nxt;
  logic             last;

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a        (a_q[CHUNK-1:0]),
    .b        (b_q[CHUNK-1:0]),
    .c_in     (carry_q),
    .sum      (sum),
    .c_out    (c_top),
    .c_msb_in (c_msb)
  );

  // New digit enters at the top; after N shifts the LSB digit lands at bit 0.
  assign res_nxt = (res_q >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
  assign last    = (cnt_q == CntW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          res_q   <= res_nxt;
          carry_q <= c_top;
          if (last) begin
            c_out_q     <= c_top;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SEQ_ADDSUB_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (state_q == StRun && last) begin
      ovf_q  <= c_msb ^ c_top;
      zero_q <= (res_nxt == '0);
    end
  end

  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
  assign bus.ovf      = 1'b0;
  assign bus.zero     = 1'b0;
`endif

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed self-checking bench: CHUNK=4 main instance plus CHUNK=1 and CHUNK=32 latency variants.
module tb_seq_addsub;

`ifdef SEQ_ADDSUB_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  logic [31:0] tb_a;
  logic [31:0] tb_b;
  logic        tb_sub;
  logic [2:0]  vld;
  logic [2:0]  ordy;

  logic [2:0]  ov;
  logic [2:0]  ir;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [2:0]  zr;
  logic [31:0] rs [3];

  seq_addsub_if #(.WIDTH(32)) bus4 ();
  seq_addsub_if #(.WIDTH(32)) bus1 ();
  seq_addsub_if #(.WIDTH(32)) bus32 ();

  seq_addsub #(.WIDTH(32), .CHUNK(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  seq_addsub #(.WIDTH(32), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  seq_addsub #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  assign bus4.a  = tb_a;  assign bus4.b  = tb_b;  assign bus4.sub  = tb_sub;
  assign bus1.a  = tb_a;  assign bus1.b  = tb_b;  assign bus1.sub  = tb_sub;
  assign bus32.a = tb_a;  assign bus32.b = tb_b;  assign bus32.sub = tb_sub;
  assign bus4.in_valid  = vld[0];  assign bus4.out_ready  = ordy[0];
  assign bus1.in_valid  = vld[1];  assign bus1.out_ready  = ordy[1];
  assign bus32.in_valid = vld[2];  assign bus32.out_ready = ordy[2];

  assign ov = {bus32.out_valid, bus1.out_valid, bus4.out_valid};
  assign ir = {bus32.in_ready, bus1.in_ready, bus4.in_ready};
  assign co = {bus32.c_out, bus1.c_out, bus4.c_out};
  assign of = {bus32.ovf, bus1.ovf, bus4.ovf};
  assign zr = {bus32.zero, bus1.zero, bus4.zero};
  assign rs[0] = bus4.res;
  assign rs[1] = bus1.res;
  assign rs[2] = bus32.res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation on instance idx with out_ready high and check latency and results.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] er, input logic ec,
                        input logic eo, input logic ez, input int lat, input string tag);
    int cyc;
    @(negedge clk);
    tb_a   = a;
    tb_b   = b;
    tb_sub = s;
    vld[idx] = 1'b1;
    @(negedge clk);
    vld[idx] = 1'b0;
    cyc = 0;
    while (!ov[idx] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " res"}, rs[idx], er);
    chk({tag, " c_out"}, co[idx], ec);
    chk({tag, " ovf"}, of[idx], eo & FlagsEn);
    chk({tag, " zero"}, zr[idx], ez & FlagsEn);
    @(negedge clk);
    chk({tag, " in_ready after"}, ir[idx], 1'b1);
    chk({tag, " out_valid after"}, ov[idx], 1'b0);
  endtask

  initial begin
    int   cyc;
    logic seen;

    rst    = 1'b1;
    tb_a   = '0;
    tb_b   = '0;
    tb_sub = 1'b0;
    vld    = '0;
    ordy   = 3'b111;
    repeat (2) @(negedge clk);

    chk("reset in_ready", ir[0], 1'b1);
    chk("reset out_valid", ov[0], 1'b0);
    chk("reset res", rs[0], 32'h0);
    chk("reset c_out", co[0], 1'b0);
    chk("reset ovf", of[0], 1'b0);
    chk("reset zero", zr[0], 1'b0);
    rst = 1'b0;

    run_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 8, "add 5+3");
    run_op(0, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 8, "sub 5-3");
    run_op(0, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 8, "sub 3-5");
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 8, "add wrap");
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 8, "add ovf");
    run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 8, "sub ovf");

    // Backpressure with operand churn during RUN.
    ordy[0] = 1'b0;
    @(negedge clk);
    tb_a   = 32'h1234_5678;
    tb_b   = 32'h1111_1111;
    tb_sub = 1'b0;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    cyc = 0;
    while (!ov[0] && cyc < 100) begin
      tb_a   = $urandom;
      tb_b   = $urandom;
      tb_sub = ~tb_sub;
      @(negedge clk);
      cyc++;
    end
    chk("bp latency", cyc, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp out_valid held", ov[0], 1'b1);
      chk("bp in_ready low", ir[0], 1'b0);
      chk("bp res held", rs[0], 32'h2345_6789);
      chk("bp c_out held", co[0], 1'b0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp in_ready after", ir[0], 1'b1);
    chk("bp out_valid after", ov[0], 1'b0);

    // Reset while digit 3 is in flight.
    @(negedge clk);
    tb_a   = 32'h0000_0005;
    tb_b   = 32'h0000_0003;
    tb_sub = 1'b0;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun rst in_ready", ir[0], 1'b1);
    chk("midrun rst out_valid", ov[0], 1'b0);
    chk("midrun rst res", rs[0], 32'h0);
    chk("midrun rst c_out", co[0], 1'b0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | ov[0];
    end
    chk("midrun rst no out_valid", seen, 1'b0);

    run_op(1, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32, "c1 add");
    run_op(2, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1, "c32 add");
    run_op(2, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1, "c32 sub");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
